retire_trace_buf: RTL
=====================

# retire_trace_buf

Parametrised, synthesizable retirement-trace recorder for the single-cycle RISC-V core. It samples every retired instruction (PC, instruction word, register write-back) into a circular buffer with a per-entry cycle stamp. It supports trigger-on-PC start, stop-on-full or overwrite mode, and automatic halt detection. A ready/valid pop port drains the buffer, so core behaviour is checked by draining entries instead of monitoring internal hierarchy.

## Interface
- XLEN, 32, data/address width
- DEPTH, 16, buffer entries; power of two, ≥2
- CYCLE_W, 32, cycle-stamp width
- HALT_REPEAT, 4, consecutive retirements at the same PC that declare a halt; ≥2

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low (0 = reset)
- retire_valid  in  1  an instruction retires this cycle
- pc  in  XLEN  PC of the retiring instruction
- instr  in  32  instruction word
- rd_we  in  1  register write enable of the retiring instruction
- rd_addr  in  5  destination register
- rd_wdata  in  XLEN  write-back value
- trig_en  in  1  1 = wait for trig_pc before capturing; 0 = capture from reset release
- trig_pc  in  XLEN  trigger PC
- wrap_mode  in  1  1 = overwrite oldest when full; 0 = drop when full
- out_ready  in  1  consumer accepts head entry
- out_valid  out  1  buffer non-empty
- out_pc, out_rd_wdata  out  XLEN  head entry fields
- out_instr  out  32  head entry field
- out_rd_we  out  1  head entry field
- out_rd_addr  out  5  head entry field
- out_cycle  out  CYCLE_W  head entry cycle stamp
- count  out  $clog2(DEPTH)+1  valid entries
- overflow  out  1  sticky; an entry was dropped or overwritten
- halted  out  1  sticky; halt detected
- cycle_cnt  out  CYCLE_W  free-running cycle counter

## Operation
- FSM states: ARMED, CAPTURE, HALTED.
- On reset the FSM enters ARMED if trig_en=1, else CAPTURE. The state transition takes effect on the first cycle after reset deasserts.
- ARMED → CAPTURE: retire_valid=1 and pc==trig_pc. That triggering instruction is itself captured.
- CAPTURE → HALTED: a captured retirement has instr==32'h00000073 (ecall), or the same pc retires HALT_REPEAT consecutive times. The halting retirement is captured. In HALTED, no further pushes occur; pops continue.
- The repeat counter resets whenever pc differs from the previous retired pc. It does not count cycles with retire_valid=0.
- Push: retire_valid=1 in CAPTURE. The entry stores all input fields plus the cycle_cnt value of that cycle.
- Full (count==DEPTH), wrap_mode=0: the push is dropped and overflow is set. The exception is a simultaneous pop, in which case the push is accepted.
- Full, wrap_mode=1: the push overwrites the oldest entry, the read pointer advances, count stays at DEPTH, and overflow is set.
- Full, wrap_mode=1, with a simultaneous pop: the consumer receives the current head, and the push is written normally. Count stays DEPTH and overflow is not set.
- Pop: out_valid & out_ready advances the read pointer. Pop when empty has no effect.
- Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH.
- cycle_cnt wraps modulo 2^CYCLE_W.
- wrap_mode and trig_en are sampled every cycle. trig_en only matters in ARMED.

## Timing
- Reset values: count=0, out_valid=0, overflow=0, halted=0, cycle_cnt=0, pointers=0. The out_* data fields are X-tolerant while out_valid=0 but are driven 0 after reset.
- Push latency is 1: an entry written at edge N is visible on out_* after edge N if it is the head. out_valid rises the cycle after the first push.
- out_* are combinational reads of the head entry and change only on clock edges.
- halted asserts the cycle after the halting retirement's edge.
- Reset asserted mid-capture clears all state on that edge. Buffer contents become invalid (count=0) and cycle_cnt restarts at 0.

## Test plan
- Basic capture: trig_en=0; retire pc=0,4,8 with rd_we=1, rd_addr=1, rd_wdata=5,10,15; then drain. Expected: 3 entries in order, out_cycle strictly increasing, count returns to 0.
- Trigger: trig_en=1, trig_pc=0x10; retire pc 0x0–0x1C in steps of 4. Expected: first popped pc=0x10, count=4.
- Drop mode, DEPTH=16: 20 retirements with no pops. Expected: count=16, overflow=1, entries hold retirements 0–15.
- Wrap mode, DEPTH=16: 20 retirements with no pops. Expected: count=16, overflow=1, head pc equals that of retirement 4.
- Full with simultaneous push and pop, in each mode. Expected: count stays 16, popped entry is the old head, new entry is at the tail, overflow stays 0.
- Halt: retire pc=0x20 five times, then ecall at a new PC after reset. Expected: halted=1 after the 4th retirement at 0x20, exactly 4 entries, no later pushes. The ecall entry is captured and halted=1 follows on the next cycle.
- Reset mid-run: pulse reset=0 for 1 cycle. Expected: count=0, halted=0, overflow=0, cycle_cnt=0 on the next cycle.

Source files
------------

// File: rtl/retire_trace_buf.sv
// Retirement trace recorder: captures retired instructions into a circular
// buffer with cycle stamps, PC trigger, drop/overwrite modes and halt detect.
module retire_trace_buf #(
    parameter int XLEN        = 32,
    parameter int DEPTH       = 16,
    parameter int CYCLE_W     = 32,
    parameter int HALT_REPEAT = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   retire_valid,
    input  logic [XLEN-1:0]        pc,
    input  logic [31:0]            instr,
    input  logic                   rd_we,
    input  logic [4:0]             rd_addr,
    input  logic [XLEN-1:0]        rd_wdata,
    input  logic                   trig_en,
    input  logic [XLEN-1:0]        trig_pc,
    input  logic                   wrap_mode,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [XLEN-1:0]        out_pc,
    output logic [31:0]            out_instr,
    output logic                   out_rd_we,
    output logic [4:0]             out_rd_addr,
    output logic [XLEN-1:0]        out_rd_wdata,
    output logic [CYCLE_W-1:0]     out_cycle,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   halted,
    output logic [CYCLE_W-1:0]     cycle_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int RW = $clog2(HALT_REPEAT + 1);
    localparam logic [31:0]   ECALL   = 32'h0000_0073;
    localparam logic [CW-1:0] FULL    = CW'(DEPTH);
    localparam logic [RW-1:0] REP_MAX = RW'(HALT_REPEAT);

    typedef enum logic [1:0] {ARMED, CAPTURE, HALTED} state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [XLEN-1:0]    r_mem_pc    [DEPTH];
    logic [31:0]        r_mem_instr [DEPTH];
    logic               r_mem_we    [DEPTH];
    logic [4:0]         r_mem_addr  [DEPTH];
    logic [XLEN-1:0]    r_mem_wdata [DEPTH];
    logic [CYCLE_W-1:0] r_mem_cyc   [DEPTH];

    logic [AW-1:0]      r_wptr;
    logic [AW-1:0]      r_rptr;
    logic [CW-1:0]      r_count;
    logic               r_ovf;
    logic [CYCLE_W-1:0] r_cycle;
    logic [XLEN-1:0]    r_prev_pc;
    logic               r_prev_vld;
    logic [RW-1:0]      r_rep;

    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic          w_push;
    logic          w_wr;
    logic          w_radv;
    logic          w_ovf_evt;
    logic [RW-1:0] w_rep_nxt;
    logic [CW-1:0] w_count_nxt;

    assign w_full  = (r_count == FULL);
    assign w_empty = (r_count == '0);
    assign w_pop   = !w_empty && out_ready;

    // Saturating run length of the current PC; reaching REP_MAX means halt.
    assign w_rep_nxt = (r_prev_vld && pc == r_prev_pc)
                     ? ((r_rep == REP_MAX) ? r_rep : r_rep + 1'b1)
                     : RW'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        case (r_state)
            ARMED: begin
                if (!trig_en || (retire_valid && pc == trig_pc)) begin
                    w_push      = retire_valid;
                    w_state_nxt = CAPTURE;
                end
            end
            CAPTURE: w_push = retire_valid;
            default: w_push = 1'b0;
        endcase
        if (w_push && (instr == ECALL || w_rep_nxt == REP_MAX))
            w_state_nxt = HALTED;
    end

    // A full buffer still takes the push when a pop frees a slot or in wrap
    // mode; wrap without a pop drags the read pointer along.
    assign w_wr        = w_push && (!w_full || w_pop || wrap_mode);
    assign w_ovf_evt   = w_push && w_full && !w_pop;
    assign w_radv      = w_pop || (w_wr && w_full);
    assign w_count_nxt = r_count + CW'(w_wr) - CW'(w_radv);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= trig_en ? ARMED : CAPTURE;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_ovf      <= 1'b0;
            r_cycle    <= '0;
            r_prev_pc  <= '0;
            r_prev_vld <= 1'b0;
            r_rep      <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_cycle <= r_cycle + 1'b1;
            if (w_wr)
                r_wptr <= r_wptr + 1'b1;
            if (w_radv)
                r_rptr <= r_rptr + 1'b1;
            if (w_ovf_evt)
                r_ovf <= 1'b1;
            if (retire_valid) begin
                r_prev_pc  <= pc;
                r_prev_vld <= 1'b1;
                r_rep      <= w_rep_nxt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem_pc[r_wptr]    <= pc;
            r_mem_instr[r_wptr] <= instr;
            r_mem_we[r_wptr]    <= rd_we;
            r_mem_addr[r_wptr]  <= rd_addr;
            r_mem_wdata[r_wptr] <= rd_wdata;
            r_mem_cyc[r_wptr]   <= r_cycle;
        end
    end

    // Head fields read as zero while empty so stale data never leaks out.
    assign out_valid    = !w_empty;
    assign out_pc       = w_empty ? '0 : r_mem_pc[r_rptr];
    assign out_instr    = w_empty ? '0 : r_mem_instr[r_rptr];
    assign out_rd_we    = w_empty ? 1'b0 : r_mem_we[r_rptr];
    assign out_rd_addr  = w_empty ? '0 : r_mem_addr[r_rptr];
    assign out_rd_wdata = w_empty ? '0 : r_mem_wdata[r_rptr];
    assign out_cycle    = w_empty ? '0 : r_mem_cyc[r_rptr];

    assign count     = r_count;
    assign overflow  = r_ovf;
    assign halted    = (r_state == HALTED);
    assign cycle_cnt = r_cycle;

endmodule
